// File: rtl/gf_div_arb.sv
// Round-robin arbiter feeding one shared combinational GF(2^8) divider.
// The quotient, requester id and divide-by-zero flag land in a single skid-free result register.

module gf_div #(
  parameter int m    = 255,
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] y,
  output logic            dz
);
  // Field polynomial x^8+x^4+x^3+x+1; the implicit top bit is handled by the shift.
  localparam logic [SIZE-1:0] POLY = SIZE'('h1B);
  localparam int              EB   = $clog2(m + 1);
  localparam logic [EB-1:0]   EXP  = EB'(m - 1);

  function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] x, input logic [SIZE-1:0] w);
    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] sh;
    acc = '0;
    sh  = x;
    for (int i = 0; i < SIZE; i++) begin
      if (w[i]) acc = acc ^ sh;
      sh = sh[SIZE-1] ? ((sh << 1) ^ POLY) : (sh << 1);
    end
    return acc;
  endfunction

  // b^(m-1) is the multiplicative inverse of b, computed by square-and-multiply.
  function automatic logic [SIZE-1:0] gf_inv(input logic [SIZE-1:0] x);
    logic [SIZE-1:0] r;
    r = SIZE'(1);
    for (int i = EB - 1; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (EXP[i]) r = gf_mul(r, x);
    end
    return r;
  endfunction

  always_comb begin
    dz = (b == '0);
    y  = dz ? '0 : gf_mul(a, gf_inv(b));
  end
endmodule

module gf_div_arb #(
  parameter int N    = 4,
  parameter int M    = 255,
  parameter int SIZE = 8,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  input  logic [N*SIZE-1:0] req_a,
  input  logic [N*SIZE-1:0] req_b,
  output logic [N-1:0]      req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [SIZE-1:0]   rsp_y,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_dz
);
  localparam int CW = IDW + 1;

  logic            can_accept;
  logic            hit;
  logic            accept;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  sel;
  logic [CW-1:0]   cand;
  logic [N-1:0]    grant;
  logic [SIZE-1:0] a_sel;
  logic [SIZE-1:0] b_sel;
  logic [SIZE-1:0] div_y;
  logic            div_dz;

  assign can_accept = !rsp_valid || rsp_ready;

  // Arbitration: first valid requester at or above ptr, wrapping modulo N.
  always_comb begin
    grant = '0;
    sel   = '0;
    hit   = 1'b0;
    cand  = '0;
    if (can_accept) begin
      for (int k = 0; k < N; k++) begin
        cand = {1'b0, ptr} + CW'(k);
        if (cand >= CW'(N)) cand = cand - CW'(N);
        if (!hit && req_valid[cand[IDW-1:0]]) begin
          hit   = 1'b1;
          sel   = cand[IDW-1:0];
          grant[cand[IDW-1:0]] = 1'b1;
        end
      end
    end
  end

  // Gating with rst_n keeps req_ready low throughout reset without waiting for a clock.
  assign req_ready = grant & {N{rst_n}};
  assign accept    = hit && rst_n;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == IDW'(i)) begin
        a_sel = req_a[i*SIZE +: SIZE];
        b_sel = req_b[i*SIZE +: SIZE];
      end
    end
  end

  gf_div #(.m(M), .SIZE(SIZE)) u_div (
    .a  (a_sel),
    .b  (b_sel),
    .y  (div_y),
    .dz (div_dz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (sel == IDW'(N - 1)) ? '0 : sel + 1'b1;
    end
  end

  // Result stage: an accept always reloads, so a drain and a refill in one cycle leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      rsp_dz    <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_y     <= div_y;
      rsp_id    <= sel;
      rsp_dz    <= div_dz;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gf_div_arb.sv
// Self-checking bench for gf_div_arb: directed vectors, corner sequences and a
// randomized run scored against a log/antilog GF(2^8) model.

module tb_gf_div_arb;
  localparam int N    = 4;
  localparam int SIZE = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N*SIZE-1:0] req_a;
  logic [N*SIZE-1:0] req_b;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [SIZE-1:0]   rsp_y;
  logic [1:0]        rsp_id;
  logic              rsp_dz;

  gf_div_arb #(.N(N), .M(255), .SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_dz    (rsp_dz)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_t [0:255];
  int         log_t [0:255];

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       dz;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] y;
    logic       dz;
  } rsp_t;

  vec_t vt [6];
  rsp_t rq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Returns {dz, y}: quotient via discrete logs w.r.t. generator 0x03.
  function automatic logic [8:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    int e;
    if (b == 8'h00) return {1'b1, 8'h00};
    if (a == 8'h00) return {1'b0, 8'h00};
    e = (log_t[a] - log_t[b] + 255) % 255;
    return {1'b0, exp_t[e]};
  endfunction

  task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*SIZE +: SIZE] = a;
    req_b[id*SIZE +: SIZE] = b;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] x;
    logic [8:0] r;
    logic [8:0] held;
    int g;

    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x ^ xtime(x);
    end
    exp_t[255] = 8'h01;
    log_t[0] = 0;

    vt[0] = '{0, 8'h53, 8'h53, 8'h01, 1'b0};
    vt[1] = '{2, 8'h37, 8'h01, 8'h37, 1'b0};
    vt[2] = '{2, 8'h00, 8'h9A, 8'h00, 1'b0};
    vt[3] = '{1, 8'h12, 8'h00, 8'h00, 1'b1};
    vt[4] = '{3, 8'h01, 8'h53, 8'hCA, 1'b0};
    vt[5] = '{1, 8'hC1, 8'h83, 8'h57, 1'b0};

    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;

    // Reset state, with requests present and before any clock edge.
    #2 req_valid = '1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_y", 32'(rsp_y), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_dz", 32'(rsp_dz), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(rsp_valid), 32'h0);
    check("rst_hold_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      req_valid = 4'(1 << vt[i].id);
      set_op(vt[i].id, vt[i].a, vt[i].b);
      rsp_ready = 1'b1;
      @(negedge clk);
      check("tbl_grant", 32'(req_ready), 32'(1 << vt[i].id));
      @(posedge clk);
      #1;
      req_valid = '0;
      check("tbl_valid", 32'(rsp_valid), 32'h1);
      check("tbl_y", 32'(rsp_y), 32'(vt[i].y));
      check("tbl_id", 32'(rsp_id), 32'(vt[i].id));
      check("tbl_dz", 32'(rsp_dz), 32'(vt[i].dz));
    end

    // Fairness: all requesters valid, consumer always ready.
    pulse_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) set_op(i, 8'($urandom), 8'($urandom_range(1, 255)));
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) begin
        r = ref_div(req_a[((k-1)%4)*SIZE +: SIZE], req_b[((k-1)%4)*SIZE +: SIZE]);
        check("fair_valid", 32'(rsp_valid), 32'h1);
        check("fair_id", 32'(rsp_id), 32'((k - 1) % 4));
        check("fair_y", 32'(rsp_y), 32'(r[7:0]));
      end
      @(posedge clk);
      #1;
    end
    check("fair_last_id", 32'(rsp_id), 32'h3);

    // Backpressure: hold for three cycles, then drain and refill without a bubble.
    req_valid = 4'b0001;
    set_op(0, 8'h57, 8'h83);
    held = ref_div(8'h57, 8'h83);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    set_op(1, 8'hC1, 8'h57);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_ready_low", 32'(req_ready), 32'h0);
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_id", 32'(rsp_id), 32'h0);
      check("bp_y", 32'(rsp_y), 32'(held[7:0]));
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    check("bp_nobubble_valid", 32'(rsp_valid), 32'h1);
    check("bp_new_id", 32'(rsp_id), 32'h1);
    check("bp_new_y", 32'(rsp_y), 32'h83);

    // Reset while a result is held.
    req_valid = 4'b0001;
    set_op(0, 8'h11, 8'h22);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_y", 32'(rsp_y), 32'h0);
    check("mid_rst_id", 32'(rsp_id), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_no_stale", 32'(rsp_valid), 32'h0);
    req_valid = 4'b1000;
    set_op(3, 8'hC1, 8'h83);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("mid_grant3", 32'(req_ready), 32'h8);
    @(posedge clk);
    #1;
    req_valid = '0;
    check("mid_valid", 32'(rsp_valid), 32'h1);
    check("mid_id", 32'(rsp_id), 32'h3);
    check("mid_y", 32'(rsp_y), 32'h57);

    // Randomized traffic against the queue-based reference.
    pulse_reset();
    rq.delete();
    g = 0;
    begin
      int mptr;
      mptr = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        @(posedge clk);
        #1;
        req_valid = 4'($urandom);
        for (int i = 0; i < N; i++)
          set_op(i, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                    ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
        rsp_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);
        check("rnd_valid", 32'(rsp_valid), 32'(rq.size() != 0));
        if (rsp_valid && rq.size() != 0) begin
          check("rnd_id", 32'(rsp_id), 32'(rq[0].id));
          check("rnd_y", 32'(rsp_y), 32'(rq[0].y));
          check("rnd_dz", 32'(rsp_dz), 32'(rq[0].dz));
          if (rsp_ready) void'(rq.pop_front());
        end
        g = -1;
        if (rq.size() == 0) begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
          end
        end
        check("rnd_grant", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'h0);
        if (g >= 0) begin
          r = ref_div(req_a[g*SIZE +: SIZE], req_b[g*SIZE +: SIZE]);
          rq.push_back('{g, r[7:0], r[8]});
          mptr = (g + 1) % N;
        end
      end
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gf_div_arb.md
GF_DIV_ARB -- requirements
Module: gf_div_arb

Interface
REQ-001 Parameters SHALL be: N, default 4, number of requesters; M, default 255, multiplicative group order of GF(2^8); SIZE, default 8, symbol width.
REQ-002 Clock and reset SHALL be: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-003 Ports SHALL be, in order:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  per-requester operation valid.
- req_a  in  N*SIZE  dividends; requester i occupies bits [i*SIZE +: SIZE].
- req_b  in  N*SIZE  divisors, packed the same way.
- req_ready  out  N  one-hot grant/accept; all zeros when nothing is accepted.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_y  out  SIZE  quotient a/b in GF(2^8).
- rsp_id  out  clog2(N)  index of the originating requester.
- rsp_dz  out  1  divide-by-zero flag.
REQ-004 The block SHALL contain exactly one instance of the team's combinational gf_div (m=M, SIZE=SIZE), shared by all requesters.

Function
REQ-005 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1; a response transfer SHALL occur in a cycle where rsp_valid and rsp_ready are both 1.
REQ-006 can_accept SHALL equal (!rsp_valid) | rsp_ready; req_ready SHALL be combinational and SHALL be all zeros when can_accept=0.
REQ-007 When can_accept=1, the grant SHALL be round-robin. Search starts at pointer ptr and runs upward modulo N; the first i with req_valid[i]=1 is granted.
REQ-008 After a grant to requester i, ptr SHALL become (i+1) mod N; with no grant, ptr SHALL hold.
REQ-009 req_ready SHALL never depend on req_a or req_b and SHALL never have more than one bit set.
REQ-010 Latency SHALL be one cycle: an operation accepted at edge t SHALL be reported by rsp_valid=1 with its rsp_y, rsp_id and rsp_dz after edge t.
REQ-011 The result register SHALL behave as follows:
- Loads on accept.
- Clears rsp_valid on a response transfer with no accept in the same cycle.
- Holds unchanged while rsp_valid=1 and rsp_ready=0.
REQ-012 A response transfer and an accept in the same cycle SHALL reload the register with the new result, with rsp_valid remaining 1 and no bubble.
REQ-013 Divide results SHALL be:
- b=0: rsp_y=0, rsp_dz=1, regardless of a.
- a=0 and b!=0: rsp_y=0, rsp_dz=0.
- Otherwise: rsp_y = gf_div(a,b), rsp_dz=0.
REQ-014 rsp_y, rsp_id and rsp_dz SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-015 A requester that deasserts req_valid without a grant SHALL lose nothing; no state is kept for ungranted requests.
REQ-016 Requester starvation SHALL be bounded: a continuously valid requester SHALL be granted within N accepts.
REQ-017 Throughput SHALL be one division per cycle when rsp_ready=1 continuously.

Reset
REQ-018 While rst_n=0, the block SHALL drive rsp_valid=0, rsp_y=0, rsp_id=0, rsp_dz=0, ptr=0 and req_ready=0, independent of clk.
REQ-019 Reset asserted mid-operation SHALL discard any held result, and no response for it SHALL appear after release.
REQ-020 The first edge after rst_n rises SHALL be a normal accept edge, with the grant starting from requester 0.

Verification
REQ-021 Single request: req0 a=0x53 b=0x53, rsp_ready=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_y=0x01, rsp_id=0, rsp_dz=0.
REQ-022 Identity and zero operands:
- req2 a=0x37 b=0x01 -> rsp_y=0x37, rsp_id=2.
- req2 a=0x00 b=0x9A -> rsp_y=0x00, rsp_dz=0.
- req1 a=0x12 b=0x00 -> rsp_y=0x00, rsp_dz=1, rsp_id=1.
REQ-023 Fairness: all four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,... and one rsp_valid per cycle.
REQ-024 Backpressure:
- Result held with rsp_ready=0 for 3 cycles -> req_ready=0000 and rsp_* unchanged for those cycles.
- rsp_ready=1 on the 4th cycle -> new result loaded the next cycle, with no bubble.
REQ-025 Reset mid-stream: rst_n low while rsp_valid=1 -> rsp_valid=0 immediately; after release, req3 alone valid -> granted, rsp_id=3.
REQ-026 Randomized check: random valid/ready patterns against a reference GF(2^8) model -> every accepted operation is answered exactly once, in order, with the correct rsp_id.
